alignment_controller: RTL

//  Command-side initiator for the systolic alignment generator.

---
 rtl/alignment_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/alignment_controller.sv
// alignment_controller: command-side initiator that clears, launches and times one generator run
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_cmd_valid / o_cmd_ready          host command handshake (accepted in IDLE)
//   o_res_valid / i_res_ready          result handshake (held in HOLD)
//   o_res_score, o_res_cycles          latched solution and run length
//   o_res_timeout                      run aborted by timeout
//   o_busy                             any state other than IDLE
//   o_gen_reset, o_gen_start           generator control levels
//   i_gen_finish, i_gen_solution       generator completion flag and score
module alignment_controller #(
    parameter int SCORE_W        = 32,
    parameter int CNT_W          = 16,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [SCORE_W-1:0] o_res_score,
    output logic [CNT_W-1:0]   o_res_cycles,
    output logic               o_res_timeout,
    output logic               o_busy,
    output logic               o_gen_reset,
    output logic               o_gen_start,
    input  logic               i_gen_finish,
    input  logic [SCORE_W-1:0] i_gen_solution
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_WAIT, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_live;
    logic [CNT_W-1:0]   r_clear_cnt;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [SCORE_W-1:0] r_res_score;
    logic [CNT_W-1:0]   r_res_cycles;
    logic               r_res_timeout;
    logic               w_finish;
    logic               w_tmo;

    // r_run_cnt is the index of the current gen_start-high cycle, so at the
    // sampling edge it already equals the number of counted edges.
    assign w_finish = (r_state == S_WAIT) && i_gen_finish;
    assign w_tmo    = (r_state == S_WAIT) && (r_run_cnt >= CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (i_cmd_valid && r_live) ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = (r_clear_cnt == CNT_W'(CLEAR_CYCLES - 1)) ? S_START : S_CLEAR;
            S_START: w_next = S_WAIT;
            S_WAIT:  w_next = (w_finish || w_tmo) ? S_HOLD : S_WAIT;
            S_HOLD:  w_next = i_res_ready ? S_IDLE : S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_live        <= 1'b0;
            r_clear_cnt   <= '0;
            r_run_cnt     <= '0;
            r_res_score   <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_live      <= 1'b1;
            r_clear_cnt <= (r_state == S_CLEAR) ? r_clear_cnt + 1'b1 : '0;
            if (r_state == S_CLEAR)
                r_run_cnt <= CNT_W'(1);
            else if (r_state == S_START || (r_state == S_WAIT && w_next == S_WAIT))
                r_run_cnt <= r_run_cnt + 1'b1;
            if (w_finish) begin
                r_res_score   <= i_gen_solution;
                r_res_cycles  <= r_run_cnt;
                r_res_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_res_score   <= '0;
                r_res_cycles  <= CNT_W'(TIMEOUT_CYCLES);
                r_res_timeout <= 1'b1;
            end
        end
    end

    // r_live keeps the generator in reset and refuses commands until the
    // first clock edge after reset release.
    assign o_cmd_ready   = r_live && (r_state == S_IDLE);
    assign o_res_valid   = (r_state == S_HOLD);
    assign o_busy        = (r_state != S_IDLE);
    assign o_gen_reset   = !r_live || (r_state == S_CLEAR);
    assign o_gen_start   = (r_state == S_START) || (r_state == S_WAIT);
    assign o_res_score   = r_res_score;
    assign o_res_cycles  = r_res_cycles;
    assign o_res_timeout = r_res_timeout;
endmodule
